// File: rtl/mmio_timer_pkg.sv
// Shared constants and types for the memory-mapped countdown timer.
// Register offsets are word indices taken from a[3:2].
package mmio_timer_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQEN    = 2;
    localparam int CTRL_PRE_LSB  = 8;
    localparam int CTRL_PRE_MSB  = 15;

    localparam int STAT_EXP     = 0;
    localparam int STAT_RUNNING = 1;

    // Only EN, PERIODIC, IRQEN and PRESCALE are stored; all other CTRL bits read 0.
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock: counts 0..limit while enabled and pulses tick on the
// cycle the count equals limit, then wraps to 0.
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] limit,
    output logic       tick
);

    logic [7:0] r_cnt;

    assign tick = en && (r_cnt == limit);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= 8'd0;
        end else if (en) begin
            r_cnt <= tick ? 8'd0 : r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with prescaler, one-shot/periodic modes and
// a sticky write-1-to-clear expiry flag driving irq.
import mmio_timer_pkg::*;

module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        irq,
    output state_t      o_state
);

    logic [31:0] r_ctrl;
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic        r_exp;
    state_t      r_state;

    logic        w_wr;
    logic [1:0]  w_off;
    logic        w_wr_ctrl;
    logic        w_wr_load;
    logic        w_wr_count;
    logic        w_wr_stat;
    logic        w_run;
    logic        w_start;
    logic        w_stop;
    logic        w_tick;
    logic        w_expire;
    logic        w_unused;

    assign sel        = (a[31:4] == BASE_ADDR[31:4]);
    assign w_off      = a[3:2];
    assign w_wr       = we & sel;
    assign w_wr_ctrl  = w_wr && (w_off == OFF_CTRL);
    assign w_wr_load  = w_wr && (w_off == OFF_LOAD);
    assign w_wr_count = w_wr && (w_off == OFF_COUNT);
    assign w_wr_stat  = w_wr && (w_off == OFF_STATUS);
    assign w_run      = (r_state == ST_RUN);
    assign w_unused   = &{1'b0, a[1:0]};

    // EN=1 only (re)starts from IDLE/DONE; in RUN it just updates fields.
    assign w_start  = w_wr_ctrl && wd[CTRL_EN] && !w_run;
    assign w_stop   = w_wr_ctrl && !wd[CTRL_EN] && (r_state != ST_IDLE);
    // A same-cycle COUNT write or stop swallows the tick, including an expiry.
    assign w_expire = w_run && w_tick && !w_stop && !w_wr_count && (r_count == 32'd0);

    timer_prescaler u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (w_start | w_stop),
        .en    (w_run),
        .limit (r_ctrl[CTRL_PRE_MSB:CTRL_PRE_LSB]),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl  <= '0;
            r_load  <= '0;
            r_count <= '0;
            r_exp   <= 1'b0;
            r_state <= ST_IDLE;
        end else begin
            if (w_wr_ctrl)  r_ctrl  <= wd & CTRL_MASK;
            if (w_wr_load)  r_load  <= wd;
            if (w_wr_count) r_count <= wd;
            if (w_wr_stat && wd[STAT_EXP]) r_exp <= 1'b0;
            // Set after the clear so a same-cycle expiry leaves EXP set.
            if (w_expire) r_exp <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_count <= r_load;
                    end
                end
                ST_RUN: begin
                    if (w_stop) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick && !w_wr_count) begin
                        if (r_count != 32'd0) begin
                            r_count <= r_count - 32'd1;
                        end else if (r_ctrl[CTRL_PERIODIC]) begin
                            r_count <= r_load;
                        end else begin
                            r_state         <= ST_DONE;
                            r_ctrl[CTRL_EN] <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_start) begin
                        r_state <= ST_RUN;
                        r_count <= r_load;
                    end else if (w_stop) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        if (sel) begin
            case (w_off)
                OFF_CTRL:  rd = r_ctrl;
                OFF_LOAD:  rd = r_load;
                OFF_COUNT: rd = r_count;
                default:   rd = {30'd0, w_run, r_exp};
            endcase
        end
    end

    assign irq     = r_exp & r_ctrl[CTRL_IRQEN];
    assign o_state = r_state;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios plus random bus traffic, all checked
// against a behavioural register/timer model through an expected-value queue.
module tb_mmio_timer;
    import mmio_timer_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam int W = 36;

    logic        clk;
    logic        reset;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        sel;
    logic        irq;
    state_t      o_state;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];

    // Behavioural model state
    bit          m_valid = 0;
    state_t      m_state;
    bit          m_en, m_per, m_irqen, m_exp;
    logic [7:0]  m_pre;
    logic [31:0] m_load, m_count;
    int          m_pc;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .a       (a),
        .wd      (wd),
        .rd      (rd),
        .sel     (sel),
        .irq     (irq),
        .o_state (o_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] model_pred(input logic [31:0] addr);
        logic [31:0] v;
        logic        s;
        s = (addr[31:4] == BASE[31:4]);
        v = '0;
        if (s) begin
            case (addr[3:2])
                2'd0: v = {16'd0, m_pre, 5'd0, m_irqen, m_per, m_en};
                2'd1: v = m_load;
                2'd2: v = m_count;
                default: v = {30'd0, m_state == ST_RUN, m_exp};
            endcase
        end
        return {m_state, m_exp & m_irqen, s, v};
    endfunction

    task automatic model_step(input logic rst_i, input logic we_i,
                              input logic [31:0] a_i, input logic [31:0] wd_i);
        bit s, wr, tick, wc, wl, wn, ws, start, stop, old_per;
        logic [31:0] old_load, old_count;
        state_t old_state;
        if (rst_i) begin
            m_state = ST_IDLE; m_en = 0; m_per = 0; m_irqen = 0; m_exp = 0;
            m_pre = '0; m_load = '0; m_count = '0; m_pc = 0;
            return;
        end
        s     = (a_i[31:4] == BASE[31:4]);
        wr    = we_i && s;
        wc    = wr && (a_i[3:2] == 2'd0);
        wl    = wr && (a_i[3:2] == 2'd1);
        wn    = wr && (a_i[3:2] == 2'd2);
        ws    = wr && (a_i[3:2] == 2'd3);
        tick  = (m_state == ST_RUN) && (m_pc == int'(m_pre));
        start = wc && wd_i[0] && (m_state != ST_RUN);
        stop  = wc && !wd_i[0] && (m_state != ST_IDLE);
        old_per = m_per; old_load = m_load; old_count = m_count; old_state = m_state;
        if (wc) begin
            m_en = wd_i[0]; m_per = wd_i[1]; m_irqen = wd_i[2]; m_pre = wd_i[15:8];
        end
        if (wl) m_load = wd_i;
        if (wn) m_count = wd_i;
        if (ws && wd_i[0]) m_exp = 0;
        if (start) begin
            m_state = ST_RUN; m_count = old_load; m_pc = 0;
        end else if (stop) begin
            m_state = ST_IDLE; m_pc = 0;
        end else if (old_state == ST_RUN) begin
            if (tick && !wn) begin
                if (old_count > 0) m_count = old_count - 1;
                else begin
                    m_exp = 1;
                    if (old_per) m_count = old_load;
                    else begin m_en = 0; m_state = ST_DONE; end
                end
            end
            m_pc = tick ? 0 : (m_pc + 1) % 256;
        end
    endtask

    task automatic bus_op(input logic rst_i, input logic we_i,
                          input logic [31:0] a_i, input logic [31:0] wd_i);
        @(negedge clk);
        reset = rst_i; we = we_i; a = a_i; wd = wd_i;
        if (m_valid) exp_q.push_back(model_pred(a_i));
        model_step(rst_i, we_i, a_i, wd_i);
        if (rst_i) m_valid = 1;
    endtask

    task automatic rd_op(input logic [31:0] a_i);
        bus_op(1'b0, 1'b0, a_i, 32'd0);
    endtask

    task automatic wr_op(input logic [31:0] a_i, input logic [31:0] wd_i);
        bus_op(1'b0, 1'b1, a_i, wd_i);
    endtask

    // Directed constant check of the outputs in the current cycle.
    task automatic chk_now(input string name, input state_t st, input logic e_irq,
                           input logic e_sel, input logic [31:0] e_rd);
        #2;
        checks++;
        if ({o_state, irq, sel, rd} !== {st, e_irq, e_sel, e_rd}) begin
            errors++;
            $display("FAIL %s: got state=%0d irq=%b sel=%b rd=%h, expected state=%0d irq=%b sel=%b rd=%h",
                     name, o_state, irq, sel, rd, st, e_irq, e_sel, e_rd);
        end
    endtask

    // Monitor: compares every cycle's outputs against the queued prediction.
    initial begin
        logic [W-1:0] e, got;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {o_state, irq, sel, rd};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL sb @%0t: got {state,irq,sel,rd}=%h expected %h", $time, got, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [31:0] addr, data;
        logic        rst_r, we_r;
        int          off;
        reset = 1'b1; we = 1'b0; a = '0; wd = '0;

        // Reset and empty register window
        bus_op(1'b1, 1'b0, BASE, 32'd0);
        bus_op(1'b1, 1'b0, BASE, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_op(BASE + 32'(i * 4));
            chk_now("reset_read", ST_IDLE, 1'b0, 1'b1, 32'd0);
        end
        rd_op(32'h0000_0500);
        chk_now("unselected_read", ST_IDLE, 1'b0, 1'b0, 32'd0);

        // One-shot, no prescale
        wr_op(BASE + 32'h4, 32'd3);
        wr_op(BASE + 32'h0, 32'h1);
        for (int i = 3; i >= 0; i--) begin
            rd_op(BASE + 32'h8);
            chk_now("oneshot_count", ST_RUN, 1'b0, 1'b1, 32'(i));
        end
        rd_op(BASE + 32'hC);
        chk_now("oneshot_status", ST_DONE, 1'b0, 1'b1, 32'h1);
        rd_op(BASE + 32'h0);
        chk_now("oneshot_ctrl_en_cleared", ST_DONE, 1'b0, 1'b1, 32'h0);

        // Periodic with PRESCALE=2
        wr_op(BASE + 32'hC, 32'h1);
        wr_op(BASE + 32'h4, 32'd2);
        wr_op(BASE + 32'h0, 32'h0000_0207);
        for (int i = 0; i < 9; i++) rd_op(BASE + 32'h8);
        rd_op(BASE + 32'h8);
        chk_now("periodic_reload_irq", ST_RUN, 1'b1, 1'b1, 32'd2);
        for (int i = 0; i < 7; i++) rd_op(BASE + 32'h8);
        // STATUS clear lands in the expiry cycle: EXP must survive
        wr_op(BASE + 32'hC, 32'h1);
        wr_op(BASE + 32'hC, 32'h1);
        chk_now("w1c_race_exp_kept", ST_RUN, 1'b1, 1'b1, 32'h3);
        rd_op(BASE + 32'hC);
        chk_now("w1c_cleared", ST_RUN, 1'b0, 1'b1, 32'h2);

        // COUNT write colliding with a tick
        wr_op(BASE + 32'h0, 32'h0);
        wr_op(BASE + 32'h4, 32'd20);
        wr_op(BASE + 32'h0, 32'h0000_0201);
        rd_op(BASE + 32'h8);
        rd_op(BASE + 32'h8);
        wr_op(BASE + 32'h8, 32'd5);
        rd_op(BASE + 32'h8);
        chk_now("count_write_wins", ST_RUN, 1'b0, 1'b1, 32'd5);
        rd_op(BASE + 32'h8);
        rd_op(BASE + 32'h8);
        rd_op(BASE + 32'h8);
        chk_now("count_after_tick", ST_RUN, 1'b0, 1'b1, 32'd4);

        // Reset mid-run together with a CTRL write
        wr_op(BASE + 32'h0, 32'h0);
        wr_op(BASE + 32'hC, 32'h1);
        wr_op(BASE + 32'h4, 32'd7);
        wr_op(BASE + 32'h0, 32'h0000_FF05);
        rd_op(BASE + 32'h8);
        chk_now("pre_reset_count", ST_RUN, 1'b0, 1'b1, 32'd7);
        bus_op(1'b1, 1'b1, BASE + 32'h0, 32'h0000_0003);
        for (int i = 0; i < 4; i++) begin
            rd_op(BASE + 32'(i * 4));
            chk_now("reset_midrun", ST_IDLE, 1'b0, 1'b1, 32'd0);
        end

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            rst_r = ($urandom_range(0, 199) == 0);
            off   = int'($urandom_range(0, 3));
            addr  = BASE + 32'(off * 4);
            if ($urandom_range(0, 9) == 0) addr = 32'h0000_0500 + 32'(off * 4);
            we_r  = ($urandom_range(0, 9) < 3);
            case (off)
                0: data = {16'd0, 8'($urandom_range(0, 3)), 5'($urandom), 3'($urandom)};
                1: data = 32'($urandom_range(0, 6));
                2: data = 32'($urandom_range(0, 8));
                default: data = $urandom;
            endcase
            bus_op(rst_r, we_r, addr, data);
        end
        bus_op(1'b0, 1'b0, BASE, 32'd0);

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
